// File: rtl/uart_rx_ctrl.sv
// Bus register controller for the uart_rx receiver: configuration, byte draining, back-pressure and IRQ.
// Optional RX idle-timeout counter is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic [15:0]       baud_div_o,
    output logic              rx_re_o,
    output logic              rx_stall_o,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_full_i,
    input  logic              rx_empty_i,
    output logic              irq_o
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state, state_next;
    logic        accept, wr, rd;
    logic [31:0] addr_ext;
    logic        sel_ctrl, sel_status, sel_rdata, sel_baud, sel_timeout;
    logic [31:0] rdata_mux, timeout_rd;
    logic        rx_en, irq_en, underflow, timeout, irq_q;
    logic        pop, underflow_set;
    logic [15:0] baud;
    logic [31:0] rsp_rdata_q;
    logic        unused_wdata;

    assign unused_wdata = ^cmd_wdata_i[31:16];

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_next = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept      = cmd_ready_o & cmd_valid_i & ~rst_i;
    assign wr          = accept & cmd_we_i;
    assign rd          = accept & ~cmd_we_i;
    assign addr_ext    = 32'(cmd_addr_i);
    assign sel_ctrl    = (addr_ext == 32'h0);
    assign sel_status  = (addr_ext == 32'h4);
    assign sel_rdata   = (addr_ext == 32'h8);
    assign sel_baud    = (addr_ext == 32'hC);
    assign sel_timeout = (addr_ext == 32'h10);

    // The pop happens only in the acceptance cycle; an empty queue is never popped.
    assign pop           = rd & sel_rdata & ~rx_empty_i;
    assign underflow_set = rd & sel_rdata & rx_empty_i;

    always_comb begin
        rdata_mux = 32'd0;
        if (sel_ctrl)    rdata_mux = {30'd0, irq_en, rx_en};
        if (sel_status)  rdata_mux = {28'd0, timeout, underflow, rx_full_i, rx_empty_i};
        if (sel_rdata)   rdata_mux = rx_empty_i ? 32'd0 : {24'd0, rx_data_i};
        if (sel_baud)    rdata_mux = {16'd0, baud};
        if (sel_timeout) rdata_mux = timeout_rd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_en       <= 1'b0;
            irq_en      <= 1'b0;
            baud        <= 16'd867;
            underflow   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            if (accept) rsp_rdata_q <= cmd_we_i ? 32'd0 : rdata_mux;
            if (wr && sel_ctrl) begin
                rx_en  <= cmd_wdata_i[0];
                irq_en <= cmd_wdata_i[1];
            end
            if (wr && sel_baud) baud <= cmd_wdata_i[15:0];
            // Set beats a simultaneous W1C.
            if (underflow_set)                             underflow <= 1'b1;
            else if (wr && sel_status && cmd_wdata_i[2])   underflow <= 1'b0;
            irq_q <= irq_en & (~rx_empty_i | underflow | timeout);
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeout_lim, idle_cnt, cnt_next;
    logic                 timeout_hit, cnt_clr;

    assign cnt_next    = idle_cnt + 1'b1;
    assign cnt_clr     = rx_empty_i | pop | (timeout_lim == '0);
    assign timeout_hit = ~cnt_clr & (cnt_next == timeout_lim);
    assign timeout_rd  = 32'(timeout_lim);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_lim <= '0;
            idle_cnt    <= '0;
            timeout     <= 1'b0;
        end else begin
            if (wr && sel_timeout) timeout_lim <= cmd_wdata_i[TIMEOUT_W-1:0];
            if (cnt_clr || timeout_hit) idle_cnt <= '0;
            else                        idle_cnt <= cnt_next;
            if (timeout_hit)                             timeout <= 1'b1;
            else if (wr && sel_status && cmd_wdata_i[3]) timeout <= 1'b0;
        end
    end
`else
    assign timeout    = 1'b0;
    assign timeout_rd = 32'd0;
`endif

    assign rsp_rdata_o = rsp_rdata_q;
    assign baud_div_o  = baud;
    assign rx_re_o     = pop;
    assign rx_stall_o  = ~rx_en | rx_full_i;
    assign irq_o       = irq_q;

endmodule
